// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and helpers for the command-port arbiters.
// Rev 1.0
`default_nettype none
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Index width for n requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin finder, first set req bit at or after ptr.
// Rev 1.0
`default_nettype none
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan offsets from far to near so the nearest hit to ptr is the last write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_cmd_arbiter.sv
// axi_cmd_arbiter: round-robin sharing of one master command port, with lock.
// Rev 1.0
`default_nettype none
module axi_cmd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_done,
  output logic [DATA_W-1:0]      req_rdata,
  output logic                   cmd_valid,
  output logic                   cmd_write,
  output logic [ADDR_W-1:0]      cmd_addr,
  output logic [DATA_W-1:0]      cmd_wdata,
  input  logic                   cmd_done,
  input  logic [DATA_W-1:0]      cmd_rdata,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx
);

  typedef struct packed {
    logic              write;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_r, win_cmd;
  logic [NREQ-1:0]  elig;
  logic [IDX_W-1:0] win, pick_ptr, rr_ptr, lock_owner;
  logic             found, lock_owner_vld;

  // A held lock narrows eligibility to its owner alone.
  always_comb begin
    elig     = lock_owner_vld ? (req_valid & (NREQ'(1) << lock_owner)) : req_valid;
    pick_ptr = lock_owner_vld ? lock_owner : rr_ptr;
  end

  rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick (
    .req   (elig),
    .ptr   (pick_ptr),
    .idx   (win),
    .found (found)
  );

  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_cmd.write = req_write[i];
        win_cmd.lock  = req_lock[i];
        win_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)    state_nxt = ISSUE;
      ISSUE:   if (cmd_done) state_nxt = GAP;
      GAP:                   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cmd_r          <= '0;
      cmd_valid      <= 1'b0;
      req_done       <= '0;
      req_rdata      <= '0;
      busy           <= 1'b0;
      grant_idx      <= '0;
      rr_ptr         <= '0;
      lock_owner     <= '0;
      lock_owner_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cmd_r     <= win_cmd;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            grant_idx <= win;
          end
        end
        ISSUE: begin
          if (cmd_done) begin
            cmd_valid <= 1'b0;
            req_rdata <= cmd_r.write ? '0 : cmd_rdata;
            req_done  <= NREQ'(1) << grant_idx;
          end
        end
        GAP: begin
          req_done <= '0;
          busy     <= 1'b0;
          if (cmd_r.lock) begin
            lock_owner     <= grant_idx;
            lock_owner_vld <= 1'b1;
          end else begin
            lock_owner_vld <= 1'b0;
            rr_ptr         <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_write = cmd_r.write;
  assign cmd_addr  = cmd_r.addr;
  assign cmd_wdata = cmd_r.wdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_arbiter.sv
// tb_axi_cmd_arbiter: directed + randomized checks against a behavioural arbiter/memory model.
// Rev 1.0
`default_nettype none
module tb_axi_cmd_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                   ACLK, ARESET;
  logic [NREQ-1:0]        req_valid, req_write, req_lock, req_done;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]      req_rdata, cmd_wdata, cmd_rdata;
  logic                   cmd_valid, cmd_write, cmd_done, busy;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [1:0]             grant_idx;

  axi_cmd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .cmd_valid (cmd_valid),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_done  (cmd_done),
    .cmd_rdata (cmd_rdata),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        write;
    logic        lock;
    logic [31:0] addr;
    logic [63:0] wdata;
  } cmd_s;

  cmd_s        pend [NREQ][$];
  cmd_s        cur  [NREQ];
  logic [63:0] mem  [logic [31:0]];
  int          m_ptr, m_lock_owner;
  bit          m_lock_vld;
  int          grant_log[$];
  int          n_tests, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_s mk(input logic w, input logic l, input logic [31:0] a, input logic [63:0] d);
    cmd_s c;
    c.write = w; c.lock = l; c.addr = a; c.wdata = d;
    return c;
  endfunction

  task automatic load_next(input int i);
    if (pend[i].size() > 0) begin
      cur[i]                   = pend[i].pop_front();
      req_write[i]             = cur[i].write;
      req_lock[i]              = cur[i].lock;
      req_addr[i*ADDR_W +: ADDR_W]  = cur[i].addr;
      req_wdata[i*DATA_W +: DATA_W] = cur[i].wdata;
      req_valid[i]             = 1'b1;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  // Who should own the port next, straight from the round-robin/lock rules.
  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (!(m_lock_vld && c != m_lock_owner) && req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [63:0] mem_read(input logic [31:0] a);
    if (a >= 32'h1000 || !mem.exists(a)) return 64'h0;
    return mem[a];
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_lock_vld = 0;
    m_lock_owner = 0;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
  endtask

  // One complete command: grant, master latency, completion, gap.
  task automatic step(input int lat);
    int          w, waited;
    logic [63:0] exp_rd;
    logic [3:0]  oh;
    w = model_pick();
    if (w < 0) return;
    @(posedge ACLK); #1;
    waited = 1;
    while (!cmd_valid && waited < 20) begin
      @(posedge ACLK); #1;
      waited++;
    end
    chk("grant_latency", 64'(waited), 64'(1));
    if (!cmd_valid) return;
    grant_log.push_back(int'(grant_idx));
    chk("grant_idx", 64'(grant_idx), 64'(w));
    chk("cmd_write", 64'(cmd_write), 64'(cur[w].write));
    chk("cmd_addr",  64'(cmd_addr),  64'(cur[w].addr));
    chk("cmd_wdata", cmd_wdata, cur[w].wdata);
    chk("busy_issue", 64'(busy), 64'(1));
    req_addr[w*ADDR_W +: ADDR_W]  = $urandom;
    req_wdata[w*DATA_W +: DATA_W] = {$urandom, $urandom};
    req_write[w] = ~cur[w].write;
    for (int c = 0; c < lat; c++) begin
      cmd_rdata = {$urandom, $urandom};
      @(posedge ACLK); #1;
    end
    chk("cmd_addr_hold",  64'(cmd_addr),  64'(cur[w].addr));
    chk("cmd_write_hold", 64'(cmd_write), 64'(cur[w].write));
    chk("cmd_valid_hold", 64'(cmd_valid), 64'(1));
    exp_rd = cur[w].write ? 64'h0 : mem_read(cur[w].addr);
    cmd_done = 1'b1;
    if (cmd_write) begin
      cmd_rdata = {$urandom, $urandom};
      if (cmd_addr < 32'h1000) mem[cmd_addr] = cmd_wdata;
    end else begin
      cmd_rdata = mem_read(cmd_addr);
    end
    @(posedge ACLK); #1;
    cmd_done  = 1'b0;
    cmd_rdata = {$urandom, $urandom};
    oh = 4'b0001 << w;
    chk("req_done_pulse", 64'(req_done), 64'(oh));
    chk("req_rdata", req_rdata, exp_rd);
    chk("cmd_valid_gap1", 64'(cmd_valid), 64'(0));
    chk("busy_gap", 64'(busy), 64'(1));
    if (cur[w].lock) begin
      m_lock_vld = 1; m_lock_owner = w;
    end else begin
      m_lock_vld = 0; m_ptr = (w + 1) % NREQ;
    end
    load_next(w);
    @(posedge ACLK); #1;
    chk("req_done_clear", 64'(req_done), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("cmd_valid_gap2", 64'(cmd_valid), 64'(0));
  endtask

  task automatic run_all();
    int guard;
    guard = 0;
    while (model_pick() >= 0 && guard < 100) begin
      step(int'($urandom_range(0, 3)));
      guard++;
    end
  endtask

  task automatic do_reset();
    ARESET    = 1'b1;
    req_valid = '0;
    cmd_done  = 1'b0;
    model_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int first, input int exp0, input int exp1, input int exp2);
    chk({tag, "_0"}, 64'(grant_log[first]),   64'(exp0));
    chk({tag, "_1"}, 64'(grant_log[first+1]), 64'(exp1));
    chk({tag, "_2"}, 64'(grant_log[first+2]), 64'(exp2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    n_tests = 0; n_fail = 0;
    ARESET = 1'b1; req_valid = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; cmd_done = 1'b0; cmd_rdata = '0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst_req_done",  64'(req_done),  64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_grant",     64'(grant_idx), 64'(0));
    chk("rst_rdata",     req_rdata,      64'(0));
    chk("rst_cmd_addr",  64'(cmd_addr),  64'(0));
    ARESET = 1'b0;

    // Single requester write then read-back.
    pend[0].push_back(mk(1'b1, 1'b0, 32'h20, 64'h1111_2222_3333_4444));
    pend[0].push_back(mk(1'b0, 1'b0, 32'h20, 64'h0));
    load_next(0);
    step(2);
    step(0);
    chk("t1_readback", req_rdata, 64'h1111_2222_3333_4444);

    // All four read together from reset: strict 0..3 order.
    do_reset();
    base = grant_log.size();
    for (int i = 0; i < NREQ; i++) begin
      pend[i].push_back(mk(1'b0, 1'b0, 32'h40 + 32'(8*i), 64'h0));
      load_next(i);
    end
    run_all();
    chk_log("t2_order", base, 0, 1, 2);
    chk("t2_order_3", 64'(grant_log[base+3]), 64'(3));

    // Requester 1 re-requests immediately; 2 must go first.
    base = grant_log.size();
    pend[1].push_back(mk(1'b0, 1'b0, 32'h48, 64'h0));
    pend[1].push_back(mk(1'b1, 1'b0, 32'h48, 64'h5555_6666_7777_8888));
    pend[2].push_back(mk(1'b1, 1'b0, 32'h50, 64'h0123_4567_89AB_CDEF));
    load_next(1);
    load_next(2);
    run_all();
    chk_log("t3_order", base, 1, 2, 1);

    // Locked read-modify-write by 3 while 0 waits.
    do_reset();
    base = grant_log.size();
    pend[3].push_back(mk(1'b0, 1'b1, 32'h50, 64'h0));
    pend[3].push_back(mk(1'b1, 1'b0, 32'h50, 64'h9999_AAAA_BBBB_CCCC));
    load_next(3);
    step(1);
    pend[0].push_back(mk(1'b0, 1'b0, 32'h50, 64'h0));
    load_next(0);
    run_all();
    chk_log("t4_order", base, 3, 3, 0);
    chk("t4_readback", req_rdata, 64'h9999_AAAA_BBBB_CCCC);

    // Lock owner goes quiet: port must idle until it returns.
    base = grant_log.size();
    pend[2].push_back(mk(1'b1, 1'b1, 32'h60, 64'hDEAD_BEEF_0000_0001));
    load_next(2);
    step(0);
    pend[1].push_back(mk(1'b0, 1'b0, 32'h60, 64'h0));
    load_next(1);
    repeat (4) begin
      @(posedge ACLK); #1;
      chk("t5_locked_idle", 64'(cmd_valid), 64'(0));
    end
    pend[2].push_back(mk(1'b0, 1'b0, 32'h68, 64'h0));
    load_next(2);
    run_all();
    chk_log("t5_order", base, 2, 2, 1);

    // DECERR-region write still completes; next command proceeds.
    pend[0].push_back(mk(1'b1, 1'b0, 32'h2000, 64'hFFFF_0000_FFFF_0000));
    pend[1].push_back(mk(1'b0, 1'b0, 32'h20, 64'h0));
    load_next(0);
    load_next(1);
    run_all();
    chk("t6_after_decerr", req_rdata, 64'h1111_2222_3333_4444);

    // cmd_done while idle has no effect.
    cmd_done = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    cmd_done = 1'b0;
    chk("t7_stray_done", 64'(req_done), 64'(0));
    chk("t7_stray_valid", 64'(cmd_valid), 64'(0));

    // Asynchronous reset while a command is in flight.
    pend[2].push_back(mk(1'b0, 1'b0, 32'h30, 64'h0));
    load_next(2);
    @(posedge ACLK); #1;
    chk("t8_in_issue", 64'(cmd_valid), 64'(1));
    #2 ARESET = 1'b1;
    #1;
    chk("t8_async_valid", 64'(cmd_valid), 64'(0));
    chk("t8_async_busy",  64'(busy),      64'(0));
    chk("t8_async_done",  64'(req_done),  64'(0));
    chk("t8_async_grant", 64'(grant_idx), 64'(0));
    #2 ARESET = 1'b0;
    m_ptr = 0; m_lock_vld = 0;
    base = grant_log.size();
    pend[0].push_back(mk(1'b0, 1'b0, 32'h08, 64'h0));
    pend[1].push_back(mk(1'b0, 1'b0, 32'h10, 64'h0));
    pend[3].push_back(mk(1'b0, 1'b0, 32'h18, 64'h0));
    load_next(0); load_next(1); load_next(3);
    run_all();
    chk_log("t8_order", base, 0, 1, 2);

    // Randomised traffic against the model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int n;
          n = int'($urandom_range(1, 3));
          for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'h2000 : 32'($urandom_range(0, 15) * 8);
            pend[i].push_back(mk(1'($urandom_range(0, 1)),
                                 (k == n - 1) ? 1'b0 : ($urandom_range(0, 3) == 0),
                                 a, {$urandom, $urandom}));
          end
          load_next(i);
        end
      end
      run_all();
    end
    chk("final_idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_cmd_arbiter.md
Name: axi_cmd_arbiter

Overview:
Round-robin arbiter that shares the single command port of axi4_lite_master between NREQ requesters (e.g. CPU stub, DMA stub, config loader).
- Each requester presents a write or read command; the arbiter serialises them onto cmd_valid/cmd_write/cmd_addr/cmd_wdata.
- It returns cmd_rdata and a completion pulse to the owning requester.
- It supports a lock for atomic read-modify-write sequences.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 32, command address width
DATA_W, 64, command data width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester command request, held until its req_done
req_write  in  NREQ  1 = write, 0 = read
req_lock  in  NREQ  keep ownership after this command completes
req_addr  in  NREQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  flattened write data
req_done  out  NREQ  one-cycle completion pulse to the owner
req_rdata  out  DATA_W  read data, valid while req_done is high
cmd_valid  out  1  to master cmd_valid
cmd_write  out  1  to master cmd_write
cmd_addr  out  ADDR_W  to master cmd_addr
cmd_wdata  out  DATA_W  to master cmd_wdata
cmd_done  in  1  from master; first sampled high cycle ends the command
cmd_rdata  in  DATA_W  from master, sampled when cmd_done = 1
busy  out  1  high in ISSUE or GAP
grant_idx  out  $clog2(NREQ)  current or last owner

Behaviour:
- Reset (async, ARESET = 1): state = IDLE; all outputs = 0; rr_ptr = 0; lock_owner_vld = 0.
- Reset mid-command: the in-flight command is abandoned; there is no completion pulse.
- All outputs are registered.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - If lock_owner_vld, only req_valid[lock_owner] is eligible.
  - Otherwise pick the first set req_valid scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - On a winner w: latch req_write/addr/wdata/lock of w into cmd_* registers; grant_idx = w; cmd_valid = 1; go to ISSUE.
  - Latency from req_valid to cmd_valid is exactly 1 cycle.
  - With no eligible request, stay in IDLE.
- ISSUE:
  - Hold cmd_valid and the payload stable; requester-side payload changes are ignored.
  - On cmd_done = 1: cmd_valid = 0; req_rdata = cmd_rdata for reads, 0 for writes; req_done[w] = 1; go to GAP.
  - No timeout: the master guarantees completion, including DECERR/SLVERR responses.
- GAP:
  - Lasts exactly one cycle; req_done[w] returns to 0 at its end.
  - If the latched lock = 1: lock_owner = w, lock_owner_vld = 1, rr_ptr unchanged.
  - Otherwise: lock_owner_vld = 0, rr_ptr = (w+1) mod NREQ.
  - Go to IDLE.
  - GAP plus IDLE guarantee at least 2 cycles of cmd_valid low between commands, as the master requires.
- Requester contract:
  - Deassert req_valid at the edge following the req_done cycle, or present the next command.
  - A req_valid still high in IDLE is treated as a new request.
- Lock:
  - A locked owner holds the port until it issues a command with req_lock = 0.
  - Other requesters wait; there is no starvation protection beyond this.
  - If the locked owner drops req_valid, the lock persists; the port idles.
- Simultaneous requests resolve purely by rr_ptr order.
- A req_valid rising while busy waits for IDLE.
- cmd_done outside ISSUE is ignored.
- Throughput: one command per (master latency + 3) cycles.

Decomposition:
- Package axi_arb_pkg: state enum (IDLE, ISSUE, GAP); IDX_W = $clog2(NREQ) helper; cmd_t struct {write, lock, addr, wdata}.
- Sub-module rr_pick (combinational round-robin priority finder: req vector and pointer in, winner index and found flag out), reused by later arbiters.

Test Plan:
- Single requester 0 writes 0x1111_2222_3333_4444 to 0x20, then reads 0x20 → one cmd_valid per command, req_done[0] pulses 1 cycle, req_rdata = 0x1111_2222_3333_4444, other req_done stay 0.
- Requesters 0..3 request reads together after reset → grant order 0, 1, 2, 3; each cmd_addr matches its own; every cmd_valid gap ≥ 2 cycles.
- Requesters 1 and 2 both pending after requester 1 completes → requester 2 is served before requester 1 is re-granted.
- Requester 3 issues read 0x50 with lock = 1 then write 0x50 = 0x9999_AAAA_BBBB_CCCC with lock = 0, while requester 0 requests continuously → requester 0 is not granted until after the write; a later read of 0x50 returns 0x9999_AAAA_BBBB_CCCC.
- Write to 0x2000 (DECERR region) → req_done still pulses, arbiter returns to IDLE, the next request proceeds normally.
- Assert ARESET during ISSUE → cmd_valid, req_done and busy drop asynchronously to 0; rr_ptr = 0; post-reset requests are granted from index 0.
